// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the vector ASIP.
//   It drives a word address into a synchronous instruction ROM, which returns
//   data one cycle later. It captures each returned word together with its PC,
//   and slices out the op/inst fields that ControlUnit uses in decode.
//   The stage also handles decode stalls, downstream-resolved jumps and HALT.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     When this macro is defined, the block adds saturating perf_fetched and
//     perf_bubbles counters.
//
// Parameters:
//   IW        instruction width in bits
//   AW        instruction address width (word addressed)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   imem_addr    ROM read address (data returns next cycle)
//   imem_rdata   ROM data for the previous cycle's imem_addr
//   stall        decode hazard hold; freezes PC and IF/ID
//   jmp_taken    resolved jump; redirects fetch (highest priority)
//   jmp_target   jump destination
//   ifid_valid   IF/ID holds a real instruction
//   ifid_instr   registered instruction word
//   ifid_pc      address of ifid_instr
//   op           ifid_instr[IW-1:IW-2], or 2'b00 for a bubble
//   inst         ifid_instr[IW-3:IW-4], or 2'b10 (NOP) for a bubble
//   perf_fetched valid instructions entered into IF/ID (FETCH_PERF_CNT_EN)
//   perf_bubbles bubble edges into IF/ID (FETCH_PERF_CNT_EN)
//   halted       fetch stopped on HALT
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int IW       = 32,
    parameter int AW       = 10,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          jmp_taken,
    input  logic [AW-1:0] jmp_target,
    output logic          ifid_valid,
    output logic [IW-1:0] ifid_instr,
    output logic [AW-1:0] ifid_pc,
    output logic [1:0]    op,
    output logic [1:0]    inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_bubbles,
`endif
    output logic          halted
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

    state_t        state;
    logic [AW-1:0] pc;       // next address to request
    logic [AW-1:0] req_pc;   // address of the ROM read in flight
    logic          req_valid;

    // The word returning from the ROM is a HALT (op=00, inst=11).
    logic is_halt_word;
    assign is_halt_word = (imem_rdata[IW-1:IW-2] == 2'b00) &&
                          (imem_rdata[IW-3:IW-4] == 2'b11);

    // A normal advance happens on any edge that is not a jump, not halted
    // and not stalled. This includes the edge on which a stall is released.
    logic advance;
    assign advance = !jmp_taken && (state != S_HALT) && !stall;

    // While stalled, re-read the outstanding address so that the word in
    // flight is still on imem_rdata when the stall releases.
    always_comb begin
        imem_addr = pc;
        if (state != S_HALT && stall && !jmp_taken)
            imem_addr = req_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            pc         <= RESET_ADDR;
            req_pc     <= RESET_ADDR;
            req_valid  <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            halted     <= 1'b0;
        end else if (jmp_taken) begin
            // Flush: the target enters the ROM next cycle and reaches
            // IF/ID one cycle later, giving two bubbles.
            state      <= S_RUN;
            pc         <= jmp_target;
            req_valid  <= 1'b0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else if (state == S_HALT) begin
            req_valid <= 1'b0;
        end else if (stall) begin
            state <= S_STALL;
        end else begin
            pc         <= pc + AW'(1);
            req_pc     <= pc;
            req_valid  <= 1'b1;
            ifid_valid <= req_valid;
            ifid_instr <= imem_rdata;
            ifid_pc    <= req_pc;
            if (req_valid && is_halt_word) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end else begin
                state  <= S_RUN;
            end
        end
    end

    // Present a NOP-like encoding to decode whenever IF/ID is a bubble.
    assign op   = ifid_valid ? ifid_instr[IW-1:IW-2] : 2'b00;
    assign inst = ifid_valid ? ifid_instr[IW-3:IW-4] : 2'b10;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic bubble_evt;
    assign fetch_evt  = advance && req_valid;
    assign bubble_evt = jmp_taken || (advance && !req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch_evt && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (bubble_evt && perf_bubbles != 32'hFFFF_FFFF)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. It uses a synchronous ROM model in which
//   word k = k, with a HALT word patched in where needed.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int IW = 32;
    localparam int AW = 10;
    localparam logic [IW-1:0] HALT_WORD = 32'h3000_0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          stall = 1'b0;
    logic          jmp_taken = 1'b0;
    logic [AW-1:0] jmp_target = '0;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_pc;
    logic [1:0]    op;
    logic [1:0]    inst;
    logic          halted;

    logic [IW-1:0] rom [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;

    fetch_stage #(.IW(IW), .AW(AW), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .op         (op),
        .inst       (inst),
        .halted     (halted)
    );

    // clock block
    always #5 clk = ~clk;

    // synchronous ROM model
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_valid(input string tag, input logic [AW-1:0] pc_e, input logic [IW-1:0] ins_e);
        check({tag, ".valid"}, 64'(ifid_valid), 64'd1);
        check({tag, ".pc"},    64'(ifid_pc),    64'(pc_e));
        check({tag, ".instr"}, 64'(ifid_instr), 64'(ins_e));
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, 64'(ifid_valid), 64'd0);
        check({tag, ".op"},    64'(op),         64'd0);
        check({tag, ".inst"},  64'(inst),       64'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) rom[k] = IW'(k);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_bubble("rst");
        check("rst.pc",     64'(ifid_pc),    64'd0);
        check("rst.instr",  64'(ifid_instr), 64'd0);
        check("rst.halted", 64'(halted),     64'd0);
        check("rst.addr",   64'(imem_addr),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        // first fetch latency, then a linear sequence
        tick(); check_bubble("lat1");
        tick(); check_valid("lat2", 10'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(); check_valid("seq", AW'(k), IW'(k));
        end

        // stall for 3 cycles while ifid_pc=5
        stall = 1'b1;
        #1 check("stall.addr0", 64'(imem_addr), 64'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_valid("stall.hold", 10'd5, 32'd5);
            check("stall.addr", 64'(imem_addr), 64'd6);
        end
        stall = 1'b0;
        tick(); check_valid("unstall6", 10'd6, 32'd6);
        tick(); check_valid("unstall7", 10'd7, 32'd7);
        tick(); check_valid("unstall8", 10'd8, 32'd8);

        // jump to 0x40 while ifid_pc=8
        jmp_taken = 1'b1; jmp_target = 10'h040;
        tick();
        jmp_taken = 1'b0;
        check_bubble("jmp.b1");
        tick(); check_bubble("jmp.b2");
        tick(); check_valid("jmp.tgt", 10'h040, 32'h40);

        // jump and stall together: jump wins
        stall = 1'b1; jmp_taken = 1'b1; jmp_target = 10'h100;
        tick();
        stall = 1'b0; jmp_taken = 1'b0;
        #1;
        check_bubble("jmpstall.flush");
        check("jmpstall.addr", 64'(imem_addr), 64'h100);
        tick(); check_bubble("jmpstall.b2");
        tick(); check_valid("jmpstall.tgt", 10'h100, 32'h100);

        // HALT at address 3
        rom[3] = HALT_WORD;
        jmp_taken = 1'b1; jmp_target = 10'd0;
        tick();
        jmp_taken = 1'b0;
        tick();
        tick(); check_valid("h.pc0", 10'd0, 32'd0);
        tick();
        tick(); check_valid("h.pc2", 10'd2, 32'd2);
        check("h.notyet", 64'(halted), 64'd0);
        tick();
        check_valid("h.pc3", 10'd3, HALT_WORD);
        check("h.halted", 64'(halted), 64'd1);
        check("h.op",     64'(op),     64'd0);
        check("h.inst",   64'(inst),   64'd3);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_valid("h.frozen", 10'd3, HALT_WORD);
            check("h.hold", 64'(halted),    64'd1);
            check("h.addr", 64'(imem_addr), 64'd5);
        end
        rom[3] = 32'd3;
        jmp_taken = 1'b1; jmp_target = 10'd0;
        tick();
        jmp_taken = 1'b0;
        check("h.exit", 64'(halted), 64'd0);
        check_bubble("h.exit.b1");
        tick(); check_bubble("h.exit.b2");
        tick(); check_valid("h.restart", 10'd0, 32'd0);

        // wrap from the top address
        jmp_taken = 1'b1; jmp_target = 10'h3FF;
        tick();
        jmp_taken = 1'b0;
        #1 check("wrap.addr_top", 64'(imem_addr), 64'h3FF);
        tick(); check("wrap.addr0", 64'(imem_addr), 64'd0);
        tick(); check_valid("wrap.top", 10'h3FF, 32'h3FF);
        tick(); check_valid("wrap.zero", 10'd0, 32'd0);

        // reset pulse mid-stall
        stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        check_bubble("rstmid");
        check("rstmid.pc",     64'(ifid_pc),    64'd0);
        check("rstmid.instr",  64'(ifid_instr), 64'd0);
        check("rstmid.halted", 64'(halted),     64'd0);
        check("rstmid.addr",   64'(imem_addr),  64'd0);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(); check_bubble("rstmid.lat1");
        tick(); check_valid("rstmid.lat2", 10'd0, 32'd0);
        tick(); check_valid("rstmid.pc1", 10'd1, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the vector ASIP.
- Generates the word address for the synchronous instruction ROM and captures the returned word with its PC.
- Slices out the op and inst fields that drive ControlUnit in the decode stage.
- Handles decode-stage stalls, taken jumps resolved downstream, and a HALT instruction.

Parameters:
- IW, 32, instruction width in bits.
- AW, 10, instruction address width (word-addressed).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  AW  ROM read address; data returns one cycle later.
- imem_rdata  in  IW  ROM read data for the previous cycle's imem_addr.
- stall  in  1  hazard hold from decode; freezes PC and IF/ID.
- jmp_taken  in  1  resolved jump (jmpSel qualified by condition); redirects fetch.
- jmp_target  in  AW  jump destination, sampled when jmp_taken=1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  IW  registered instruction word.
- ifid_pc  out  AW  address of ifid_instr.
- op  out  2  ifid_instr[IW-1:IW-2], or 2'b00 when ifid_valid=0.
- inst  out  2  ifid_instr[IW-3:IW-4], or 2'b10 (NOP) when ifid_valid=0.
- halted  out  1  fetch stopped on HALT.

Behaviour:
- Reset (async assert, sync release effect) sets:
  - pc=RESET_PC, req_pc=RESET_PC, req_valid=0.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, halted=0.
  - state=RUN.
- Internal state:
  - pc: next address to request.
  - req_pc / req_valid: the address and validity of the ROM read in flight.
- Bubble encoding: op=00, inst=10. Under ControlUnit decode this gives no mem, reg, jump or cond side effects.
- HALT encoding: op=00, inst=11.
- FSM states RUN, STALL, HALT.
- RUN, stall=0, jmp_taken=0:
  - imem_addr=pc; pc<=pc+1; req_pc<=pc; req_valid<=1.
  - IF/ID <= {req_valid, imem_rdata, req_pc}.
- Stall (RUN->STALL when stall=1; remain in STALL while stall=1):
  - imem_addr=req_pc, so the ROM re-reads and the outstanding word is preserved.
  - pc, req_pc, req_valid and IF/ID are all held.
  - STALL->RUN the cycle stall falls. That cycle performs a normal RUN update, so no instruction is lost or duplicated.
- jmp_taken=1 in any state (highest priority, overrides stall and HALT):
  - pc<=jmp_target; req_valid<=0; ifid_valid<=0; state<=RUN.
  - Penalty is two bubbles: target enters ROM next cycle and appears in IF/ID the cycle after.
- HALT:
  - When a valid HALT is latched into IF/ID, state<=HALT and halted<=1 on the same edge.
  - In HALT: pc and IF/ID are frozen, req_valid<=0, imem_addr=pc.
  - Exit only by reset or jmp_taken.
- pc+1 wraps modulo 2^AW silently.
- jmp_target is taken as-is; no alignment check because addressing is word-based.
- Reset mid-stall or mid-redirect: all state returns to reset values; no partial IF/ID update.
- Latency: first valid instruction at RESET_PC appears in IF/ID 2 cycles after reset release.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both reset to 0, saturating at all-ones.
  - perf_fetched increments each edge a valid instruction enters IF/ID.
  - perf_bubbles increments each non-stall, non-HALT edge where ifid_valid becomes 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset release, ROM word k = k, no stall/jump -> ifid_valid=1 at cycle 2 with ifid_pc=0, ifid_instr=0; then pc 1, 2, 3 on consecutive cycles.
- stall=1 for 3 cycles while ifid_pc=5 -> IF/ID holds pc=5 and imem_addr=6 for those cycles; after release, sequence 6, 7 with no gap or repeat.
- jmp_taken=1, jmp_target=0x40 while ifid_pc=8 -> next two cycles ifid_valid=0 with op=00, inst=10; third cycle ifid_pc=0x40.
- jmp_taken=1 and stall=1 in the same cycle -> jump wins; IF/ID flushed; pc=target.
- HALT word (op=00, inst=11) at address 3 -> halted=1 once ifid_pc=3; IF/ID frozen for 10 cycles; then jmp_taken to 0 restarts fetch and clears halted.
- Start at pc=2^AW-1 via jump -> following fetch address 0; rst pulse mid-stall -> all outputs return to reset values immediately.
